wht_2d_4x4: RTL and testbench

// - Unnormalised 4x4 2-D Walsh-Hadamard transform, Z = H4 * X * H4, streamed one 4-sample row per cycle.
// - Used as the forward transform and, re-instantiated with wider widths, as the inverse (result = 16*X).
// - H4 (natural/Sylvester order) rows: [+ + + +] [+ - + -] [+ + - -] [+ - - +].

---
 rtl/wht_pkg.sv | 19 +
 rtl/wht_1d4.sv | 30 +++
 rtl/wht_2d_4x4.sv | 125 ++++++++++++
 tb/tb_wht_2d_4x4.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wht_pkg.sv
// Shared constants and helpers for the 4x4 Walsh-Hadamard transform.
package wht_pkg;

    localparam int ROWS = 4;

    // Bit k of entry i is set where H4[i][k] = -1 (natural/Sylvester order).
    localparam logic [ROWS-1:0] H4_NEG [ROWS] = '{4'b0000, 4'b1010, 4'b1100, 4'b0110};

    // Sign-extend the low w bits of v to 32 bits.
    function automatic logic signed [31:0] sext(input logic [31:0] v, input int w);
        logic signed [31:0] r;
        r = v;
        for (int b = 0; b < 32; b++) begin
            if (b >= w) r[b] = v[w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/wht_1d4.sv
// Combinational 4-point Walsh-Hadamard butterfly: y = H4 * x.
// Inputs sign-extended to OUT_W before add/sub; results wrap if OUT_W is too
// narrow. OUT_W must not exceed 32.
module wht_1d4 import wht_pkg::*; #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 11
) (
    input  logic [ROWS*IN_W-1:0]  x,
    output logic [ROWS*OUT_W-1:0] y
);

    logic signed [OUT_W-1:0] acc;
    logic signed [OUT_W-1:0] term;

    // Signed sum of the four inputs under each H4 sign row.
    always_comb begin
        y    = '0;
        acc  = '0;
        term = '0;
        for (int i = 0; i < ROWS; i++) begin
            acc = '0;
            for (int k = 0; k < ROWS; k++) begin
                term = OUT_W'(sext(32'(x[k*IN_W +: IN_W]), IN_W));
                acc  = H4_NEG[i][k] ? acc - term : acc + term;
            end
            y[i*OUT_W +: OUT_W] = acc;
        end
    end

endmodule

// File: rtl/wht_2d_4x4.sv
// Streaming unnormalised 4x4 2-D Walsh-Hadamard transform, Z = H4 * X * H4.
// One input row per valid cycle; the row transform is stored in a ping-pong
// bank, and each completed block is read out as a 4-row burst through the
// column butterflies.
// Optional build macro: WHT_2D_OUTREG_EN adds one extra output register stage
// (pix_out0..3 and pix_ovalid), increasing latency by one cycle.
module wht_2d_4x4 import wht_pkg::*; #(
    parameter int WIDTH0 = 9,
    parameter int WIDTH1 = 11,
    parameter int WIDTH2 = 13
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [4*WIDTH0-1:0]      blk_i,
    input  logic                     blk_valid,
    output logic signed [WIDTH2-1:0] pix_out0,
    output logic signed [WIDTH2-1:0] pix_out1,
    output logic signed [WIDTH2-1:0] pix_out2,
    output logic signed [WIDTH2-1:0] pix_out3,
    output logic                     pix_ovalid
);

    logic [ROWS*WIDTH1-1:0]   row_y;
    logic [ROWS*WIDTH1-1:0]   bank_q [2][ROWS];
    logic [1:0]               wr_row_q;
    logic                     wr_bank_q;
    logic                     rd_bank_q;
    logic                     busy_q;
    logic [1:0]               out_row_q;
    logic                     start;
    logic signed [WIDTH2-1:0] z_row [ROWS];
    logic signed [WIDTH2-1:0] pix_p0 [ROWS];
    logic                     vld_p0;

    assign start = blk_valid && (wr_row_q == 2'd3);

    wht_1d4 #(.IN_W(WIDTH0), .OUT_W(WIDTH1)) u_row (.x(blk_i), .y(row_y));

    // Row stage: store the transformed input row into the write bank.
    always_ff @(posedge clk) begin
        if (blk_valid) bank_q[wr_bank_q][wr_row_q] <= row_y;
    end

    // Row/bank bookkeeping and output burst sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_row_q  <= 2'd0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            busy_q    <= 1'b0;
            out_row_q <= 2'd0;
        end else begin
            if (blk_valid) begin
                wr_row_q <= wr_row_q + 2'd1;
                if (wr_row_q == 2'd3) wr_bank_q <= ~wr_bank_q;
            end
            if (start) begin
                busy_q    <= 1'b1;
                out_row_q <= 2'd0;
                rd_bank_q <= wr_bank_q;
            end else if (busy_q) begin
                out_row_q <= out_row_q + 2'd1;
                if (out_row_q == 2'd3) busy_q <= 1'b0;
            end
        end
    end

    // Column stage: one butterfly per column, element picked by output row.
    for (genvar j = 0; j < ROWS; j++) begin : g_col
        logic [ROWS*WIDTH1-1:0] cx;
        logic [ROWS*WIDTH2-1:0] cz;

        // Gather column j of the bank being read out.
        always_comb begin
            cx = '0;
            for (int k = 0; k < ROWS; k++) begin
                cx[k*WIDTH1 +: WIDTH1] = bank_q[rd_bank_q][k][j*WIDTH1 +: WIDTH1];
            end
        end

        wht_1d4 #(.IN_W(WIDTH1), .OUT_W(WIDTH2)) u_col (.x(cx), .y(cz));

        assign z_row[j] = cz[int'(out_row_q)*WIDTH2 +: WIDTH2];
    end

    // ---- stage p0: output register, holds last row outside a burst ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            pix_p0 <= '{default: '0};
        end else begin
            vld_p0 <= busy_q;
            if (busy_q) pix_p0 <= z_row;
        end
    end

`ifdef WHT_2D_OUTREG_EN
    logic signed [WIDTH2-1:0] pix_p1 [ROWS];
    logic                     vld_p1;

    // ---- stage p1: extra output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            pix_p1 <= '{default: '0};
        end else begin
            vld_p1 <= vld_p0;
            pix_p1 <= pix_p0;
        end
    end

    assign pix_out0   = pix_p1[0];
    assign pix_out1   = pix_p1[1];
    assign pix_out2   = pix_p1[2];
    assign pix_out3   = pix_p1[3];
    assign pix_ovalid = vld_p1;
`else
    assign pix_out0   = pix_p0[0];
    assign pix_out1   = pix_p0[1];
    assign pix_out2   = pix_p0[2];
    assign pix_out3   = pix_p0[3];
    assign pix_ovalid = vld_p0;
`endif

endmodule

// File: tb/tb_wht_2d_4x4.sv
// Bench for wht_2d_4x4: forward transform chained into a wider inverse
// instance, checked against a matrix-multiply reference model.
module tb_wht_2d_4x4;

    localparam int W0 = 9, W1 = 11, W2 = 13;
    localparam int IW0 = 13, IW1 = 15, IW2 = 17;
`ifdef WHT_2D_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed { int v0; int v1; int v2; int v3; } row_t;
    typedef int mat_t [4][4];

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [4*W0-1:0]       blk_i = '0;
    logic                  blk_valid = 1'b0;
    logic signed [W2-1:0]  po0, po1, po2, po3;
    logic                  pov;
    logic signed [IW2-1:0] qo0, qo1, qo2, qo3;
    logic                  qov;
    logic [4*IW0-1:0]      inv_blk;

    assign inv_blk = {po3, po2, po1, po0};

    wht_2d_4x4 #(.WIDTH0(W0), .WIDTH1(W1), .WIDTH2(W2)) dut (
        .clk(clk), .rst_n(rst_n), .blk_i(blk_i), .blk_valid(blk_valid),
        .pix_out0(po0), .pix_out1(po1), .pix_out2(po2), .pix_out3(po3),
        .pix_ovalid(pov)
    );

    wht_2d_4x4 #(.WIDTH0(IW0), .WIDTH1(IW1), .WIDTH2(IW2)) inv (
        .clk(clk), .rst_n(rst_n), .blk_i(inv_blk), .blk_valid(pov),
        .pix_out0(qo0), .pix_out1(qo1), .pix_out2(qo2), .pix_out3(qo3),
        .pix_ovalid(qov)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    row_t got_q[$], exp_q[$], inv_q[$], inv_exp_q[$];
    int   stamp_q[$];
    int   total = 0;
    int   bad = 0;
    int   last_c = 0;

    function automatic row_t mk(int a, int b, int c, int d);
        row_t r;
        r.v0 = a; r.v1 = b; r.v2 = c; r.v3 = d;
        return r;
    endfunction

    always @(negedge clk) begin
        if (pov) begin
            got_q.push_back(mk(int'(po0), int'(po1), int'(po2), int'(po3)));
            stamp_q.push_back(cyc);
        end
        if (qov) inv_q.push_back(mk(int'(qo0), int'(qo1), int'(qo2), int'(qo3)));
    end

    // Hadamard entry in natural order: (-1)^popcount(i & k).
    function automatic int hs(int i, int k);
        return ($countones(i & k) % 2 == 1) ? -1 : 1;
    endfunction

    task automatic model(input mat_t x);
        int z [4][4];
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                z[i][j] = 0;
                for (int a = 0; a < 4; a++)
                    for (int b = 0; b < 4; b++)
                        z[i][j] += hs(i, a) * x[a][b] * hs(b, j);
            end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(z[i][0], z[i][1], z[i][2], z[i][3]));
            inv_exp_q.push_back(mk(16*x[i][0], 16*x[i][1], 16*x[i][2], 16*x[i][3]));
        end
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_row(input mat_t x, input int r);
        int t;
        for (int k = 0; k < 4; k++) begin
            t = x[r][k];
            blk_i[k*W0 +: W0] = t[W0-1:0];
        end
        blk_valid = 1'b1;
        @(posedge clk);
        #1;
        blk_valid = 1'b0;
        last_c = cyc;
    endtask

    task automatic send_block(input mat_t x, input int gmax);
        model(x);
        for (int r = 0; r < 4; r++) begin
            send_row(x, r);
            idle(int'($urandom_range(0, gmax)));
        end
    endtask

    task automatic rand_mat(output mat_t x);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                x[i][j] = int'($urandom_range(0, 511)) - 256;
    endtask

    task automatic fill_mat(output mat_t x, input int v);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                x[i][j] = v;
    endtask

    task automatic clear_q();
        got_q.delete(); exp_q.delete(); inv_q.delete(); inv_exp_q.delete(); stamp_q.delete();
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        blk_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({po0, po1, po2, po3} !== '0) begin
            bad++;
            $display("FAIL reset_out got %0d %0d %0d %0d want 0 0 0 0", po0, po1, po2, po3);
        end
        total++;
        if (pov !== 1'b0) begin
            bad++;
            $display("FAIL reset_ovalid got %b want 0", pov);
        end
        @(posedge clk); #1;
        blk_valid = 1'b0;
        rst_n = 1'b1;
        idle(6);
        total++;
        if (got_q.size() != 0) begin
            bad++;
            $display("FAIL idle_no_output got %0d rows want 0", got_q.size());
        end
    endtask

    task automatic test_pattern();
        mat_t x;
        row_t want;
        clear_q();
        for (int r = 0; r < 4; r++) begin
            x[r][0] = 128; x[r][1] = 128; x[r][2] = 0; x[r][3] = 1;
        end
        send_block(x, 0);
        idle(20);
        total++;
        if (got_q.size() != 4) begin
            bad++;
            $display("FAIL pattern_rows got %0d want 4", got_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            want = (i == 0) ? mk(1028, -4, 1020, 4) : mk(0, 0, 0, 0);
            total++;
            if (i >= got_q.size() || got_q[i] !== want) begin
                bad++;
                $display("FAIL pattern_row%0d got %0d %0d %0d %0d want %0d %0d %0d %0d", i,
                         (i < got_q.size()) ? got_q[i].v0 : 0, (i < got_q.size()) ? got_q[i].v1 : 0,
                         (i < got_q.size()) ? got_q[i].v2 : 0, (i < got_q.size()) ? got_q[i].v3 : 0,
                         want.v0, want.v1, want.v2, want.v3);
            end
        end
        total++;
        if (stamp_q.size() == 0 || stamp_q[0] != last_c + LAT) begin
            bad++;
            $display("FAIL pattern_latency got %0d want %0d",
                     (stamp_q.size() > 0) ? stamp_q[0] : -1, last_c + LAT);
        end
    endtask

    task automatic test_ones();
        mat_t x;
        row_t want;
        clear_q();
        fill_mat(x, 1);
        send_block(x, 0);
        fill_mat(x, -256);
        send_block(x, 0);
        idle(20);
        total++;
        if (got_q.size() != 8) begin
            bad++;
            $display("FAIL ones_rows got %0d want 8", got_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            want = (i == 0) ? mk(16, 0, 0, 0) : (i == 4) ? mk(-4096, 0, 0, 0) : mk(0, 0, 0, 0);
            total++;
            if (i >= got_q.size() || got_q[i] !== want) begin
                bad++;
                $display("FAIL ones_row%0d got %0d want %0d %0d %0d %0d", i,
                         (i < got_q.size()) ? got_q[i].v0 : 0, want.v0, want.v1, want.v2, want.v3);
            end
        end
    endtask

    task automatic test_random();
        mat_t x;
        clear_q();
        for (int b = 0; b < 6; b++) begin
            rand_mat(x);
            send_block(x, 3);
        end
        idle(24);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL random_rows got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL random_row%0d got %0d %0d %0d %0d want %0d %0d %0d %0d", i,
                         (i < got_q.size()) ? got_q[i].v0 : 0, (i < got_q.size()) ? got_q[i].v1 : 0,
                         (i < got_q.size()) ? got_q[i].v2 : 0, (i < got_q.size()) ? got_q[i].v3 : 0,
                         exp_q[i].v0, exp_q[i].v1, exp_q[i].v2, exp_q[i].v3);
            end
        end
        for (int i = 0; i < inv_exp_q.size(); i++) begin
            total++;
            if (i >= inv_q.size() || inv_q[i] !== inv_exp_q[i]) begin
                bad++;
                $display("FAIL inverse_row%0d got %0d %0d %0d %0d want %0d %0d %0d %0d", i,
                         (i < inv_q.size()) ? inv_q[i].v0 : 0, (i < inv_q.size()) ? inv_q[i].v1 : 0,
                         (i < inv_q.size()) ? inv_q[i].v2 : 0, (i < inv_q.size()) ? inv_q[i].v3 : 0,
                         inv_exp_q[i].v0, inv_exp_q[i].v1, inv_exp_q[i].v2, inv_exp_q[i].v3);
            end
        end
    endtask

    task automatic test_back_to_back();
        mat_t x;
        clear_q();
        for (int b = 0; b < 2; b++) begin
            rand_mat(x);
            send_block(x, 0);
        end
        idle(20);
        total++;
        if (stamp_q.size() != 8) begin
            bad++;
            $display("FAIL b2b_rows got %0d want 8", stamp_q.size());
        end
        for (int i = 1; i < stamp_q.size(); i++) begin
            total++;
            if (stamp_q[i] != stamp_q[i-1] + 1) begin
                bad++;
                $display("FAIL b2b_gap at %0d got cycle %0d want %0d", i, stamp_q[i], stamp_q[i-1] + 1);
            end
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b_row%0d got %0d want %0d", i,
                         (i < got_q.size()) ? got_q[i].v0 : 0, exp_q[i].v0);
            end
        end
    endtask

    task automatic test_gaps();
        mat_t x;
        clear_q();
        rand_mat(x);
        model(x);
        send_row(x, 0);
        send_row(x, 1);
        idle(5);
        send_row(x, 2);
        send_row(x, 3);
        idle(20);
        total++;
        if (got_q.size() != 4) begin
            bad++;
            $display("FAIL gaps_rows got %0d want 4", got_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL gaps_row%0d got %0d %0d want %0d %0d", i,
                         (i < got_q.size()) ? got_q[i].v0 : 0, (i < got_q.size()) ? got_q[i].v1 : 0,
                         exp_q[i].v0, exp_q[i].v1);
            end
        end
    endtask

    task automatic test_reset_mid();
        mat_t x;
        clear_q();
        rand_mat(x);
        send_row(x, 0);
        send_row(x, 1);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({po0, po1, po2, po3} !== '0 || pov !== 1'b0) begin
            bad++;
            $display("FAIL midreset_out got %0d %0d %0d %0d v=%b want 0 0 0 0 v=0", po0, po1, po2, po3, pov);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        rand_mat(x);
        send_block(x, 1);
        idle(20);
        total++;
        if (got_q.size() != 4) begin
            bad++;
            $display("FAIL midreset_rows got %0d want 4", got_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL midreset_row%0d got %0d %0d want %0d %0d", i,
                         (i < got_q.size()) ? got_q[i].v0 : 0, (i < got_q.size()) ? got_q[i].v3 : 0,
                         exp_q[i].v0, exp_q[i].v3);
            end
            total++;
            if (i >= inv_q.size() || inv_q[i] !== inv_exp_q[i]) begin
                bad++;
                $display("FAIL midreset_inv%0d got %0d want %0d", i,
                         (i < inv_q.size()) ? inv_q[i].v0 : 0, inv_exp_q[i].v0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_ones();
        test_random();
        test_back_to_back();
        test_gaps();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
